// File: rtl/systolic_pkg.sv
// Shared definitions for the host instruction dispatcher: instruction word layout,
// opcode values and the dispatch FSM state encoding.
package systolic_pkg;

    localparam int INSTR_W       = 32;
    localparam int OPVALID_BIT   = 31;
    localparam int OPCODE_LSB    = 28;
    localparam int OPCODE_W      = 3;
    localparam int FIELD_LSB     = 8;
    localparam int FIELD_W       = 20;
    localparam int DATA8_LSB     = 0;
    localparam int DATA8_W       = 8;
    // PSUM base address lives in the top bits of FIELD20, i.e. FIELD20[19:14]
    localparam int PSUM_BASE_OFS = 14;

    localparam logic [OPCODE_W-1:0] OPCODE_NOP     = 3'd0;
    localparam logic [OPCODE_W-1:0] OPCODE_LDSRAM  = 3'd1;
    localparam logic [OPCODE_W-1:0] OPCODE_EX      = 3'd2;
    localparam logic [OPCODE_W-1:0] OPCODE_WBPSRAM = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EX,
        S_WB_RD,
        S_WB_DRAIN,
        S_FIN
    } dispatch_state_e;

    function automatic logic is_illegal_op(input logic [OPCODE_W-1:0] op);
        return op[OPCODE_W-1];
    endfunction

endpackage

// File: rtl/psum_wb_reader.sv
// PSUM read-out engine: issues PSUM_N consecutive reads from a wrapping base address,
// aligns the 1-cycle-latency read data into registered beats and pulses finish after the last.
module psum_wb_reader #(
    parameter int PSUM_AW = 6,
    parameter int PSUM_W  = 20,
    parameter int PSUM_N  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [PSUM_AW-1:0] base_i,
    output logic               rd_en_o,
    output logic [PSUM_AW-1:0] rd_addr_o,
    input  logic [PSUM_W-1:0]  rd_data_i,
    output logic               rd_last_o,
    output logic               wb_valid_o,
    output logic [PSUM_W-1:0]  wb_data_o,
    output logic               last_beat_o,
    output logic               finish_o
);

    localparam int CNT_W = $clog2(PSUM_N + 1);

    logic               rd_en_q;
    logic [PSUM_AW-1:0] rd_addr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ret_vld_q;
    logic               ret_last_q;
    logic               wb_valid_q;
    logic               wb_last_q;
    logic [PSUM_W-1:0]  wb_data_q;
    logic               finish_q;
    logic               rd_last;

    assign rd_last = rd_en_q && (cnt_q == CNT_W'(PSUM_N - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            cnt_q      <= '0;
            ret_vld_q  <= 1'b0;
            ret_last_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_last_q  <= 1'b0;
            wb_data_q  <= '0;
            finish_q   <= 1'b0;
        end else begin
            if (start_i) begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= base_i;
                cnt_q     <= '0;
            end else if (rd_en_q) begin
                // address wraps naturally at 2**PSUM_AW
                rd_addr_q <= rd_addr_q + 1'b1;
                cnt_q     <= cnt_q + 1'b1;
                if (rd_last) begin
                    rd_en_q <= 1'b0;
                end
            end
            // read data returns one cycle after the enable, then is registered once more
            ret_vld_q  <= rd_en_q;
            ret_last_q <= rd_last;
            wb_valid_q <= ret_vld_q;
            wb_last_q  <= ret_last_q;
            if (ret_vld_q) begin
                wb_data_q <= rd_data_i;
            end
            finish_q <= wb_valid_q && wb_last_q;
        end
    end

    assign rd_en_o     = rd_en_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_last_o   = rd_last;
    assign wb_valid_o  = wb_valid_q;
    assign wb_data_o   = wb_data_q;
    assign last_beat_o = wb_valid_q && wb_last_q;
    assign finish_o    = finish_q;

endmodule

// File: rtl/instr_dispatch.sv
// Host instruction dispatcher into the systolic core: LDSRAM writes, EX handshake, PSUM writeback.
// Optional feature macro: DISPATCH_ILLEGAL_OP_EN (sticky illegal-opcode flag).
module instr_dispatch
    import systolic_pkg::*;
#(
    parameter int SRAM_AW = 7,
    parameter int DATA_W  = 8,
    parameter int PSUM_AW = 6,
    parameter int PSUM_W  = 20,
    parameter int PSUM_N  = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [31:0]        i_Instr_In,
    output logic               o_Instr_Ready,
    output logic               o_Sram_We,
    output logic [SRAM_AW-1:0] o_Sram_Addr,
    output logic [DATA_W-1:0]  o_Sram_Data,
    output logic               o_Ex_Start,
    input  logic               i_Ex_Done,
    output logic               o_Psum_Rd_En,
    output logic [PSUM_AW-1:0] o_Psum_Rd_Addr,
    input  logic [PSUM_W-1:0]  i_Psum_Rd_Data,
    output logic               o_Valid_WB_Out,
    output logic [PSUM_W-1:0]  o_Data_WB_Out,
    output logic               o_Flag_Finish_Out,
    output logic               o_Illegal_Op
);

    dispatch_state_e      state_q, state_d;
    logic [OPCODE_W-1:0]  opcode;
    logic                 accept;
    logic                 wb_start;
    logic                 sram_we_q;
    logic [SRAM_AW-1:0]   sram_addr_q;
    logic [DATA_W-1:0]    sram_data_q;
    logic                 ex_start_q;
    logic                 rd_last;
    logic                 last_beat;
    logic                 unused_instr;

    assign opcode        = i_Instr_In[OPCODE_LSB +: OPCODE_W];
    assign accept        = i_Instr_In[OPVALID_BIT] && (state_q == S_IDLE);
    assign o_Instr_Ready = (state_q == S_IDLE);
    assign unused_instr  = ^i_Instr_In;

    always_comb begin
        state_d  = state_q;
        wb_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && opcode == OPCODE_EX) begin
                    state_d = S_EX;
                end else if (accept && opcode == OPCODE_WBPSRAM) begin
                    state_d  = S_WB_RD;
                    wb_start = 1'b1;
                end
            end
            // done coinciding with the start pulse belongs to no current job
            S_EX:       if (i_Ex_Done && !ex_start_q) state_d = S_IDLE;
            S_WB_RD:    if (rd_last)                  state_d = S_WB_DRAIN;
            S_WB_DRAIN: if (last_beat)                state_d = S_FIN;
            S_FIN:                                    state_d = S_IDLE;
            default:                                  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            sram_we_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
            ex_start_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sram_we_q  <= accept && (opcode == OPCODE_LDSRAM);
            ex_start_q <= accept && (opcode == OPCODE_EX);
            if (accept && opcode == OPCODE_LDSRAM) begin
                sram_addr_q <= i_Instr_In[FIELD_LSB +: SRAM_AW];
                sram_data_q <= i_Instr_In[DATA8_LSB +: DATA_W];
            end
        end
    end

    assign o_Sram_We   = sram_we_q;
    assign o_Sram_Addr = sram_addr_q;
    assign o_Sram_Data = sram_data_q;
    assign o_Ex_Start  = ex_start_q;

    psum_wb_reader #(
        .PSUM_AW (PSUM_AW),
        .PSUM_W  (PSUM_W),
        .PSUM_N  (PSUM_N)
    ) u_reader (
        .clk_i       (CLK),
        .rst_i       (RST),
        .start_i     (wb_start),
        .base_i      (i_Instr_In[FIELD_LSB + PSUM_BASE_OFS +: PSUM_AW]),
        .rd_en_o     (o_Psum_Rd_En),
        .rd_addr_o   (o_Psum_Rd_Addr),
        .rd_data_i   (i_Psum_Rd_Data),
        .rd_last_o   (rd_last),
        .wb_valid_o  (o_Valid_WB_Out),
        .wb_data_o   (o_Data_WB_Out),
        .last_beat_o (last_beat),
        .finish_o    (o_Flag_Finish_Out)
    );

`ifdef DISPATCH_ILLEGAL_OP_EN
    logic illegal_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            illegal_q <= 1'b0;
        end else if (accept && is_illegal_op(opcode)) begin
            illegal_q <= 1'b1;
        end
    end

    assign o_Illegal_Op = illegal_q;
`else
    assign o_Illegal_Op = 1'b0;
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Randomised bench for instr_dispatch: a cycle-indexed expectation schedule derived from
// the instruction timing rules is compared against every output on each falling edge.
module tb_instr_dispatch;

    localparam int N   = 16;
    localparam int RNG = 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] i_Instr_In = '0;
    logic        i_Ex_Done = 1'b0;
    logic [19:0] psum_rd_data = '0;
    logic        o_Instr_Ready, o_Sram_We, o_Ex_Start, o_Psum_Rd_En;
    logic        o_Valid_WB_Out, o_Flag_Finish_Out, o_Illegal_Op;
    logic [6:0]  o_Sram_Addr;
    logic [7:0]  o_Sram_Data;
    logic [5:0]  o_Psum_Rd_Addr;
    logic [19:0] o_Data_WB_Out;

    instr_dispatch dut (
        .CLK               (CLK),
        .RST               (RST),
        .i_Instr_In        (i_Instr_In),
        .o_Instr_Ready     (o_Instr_Ready),
        .o_Sram_We         (o_Sram_We),
        .o_Sram_Addr       (o_Sram_Addr),
        .o_Sram_Data       (o_Sram_Data),
        .o_Ex_Start        (o_Ex_Start),
        .i_Ex_Done         (i_Ex_Done),
        .o_Psum_Rd_En      (o_Psum_Rd_En),
        .o_Psum_Rd_Addr    (o_Psum_Rd_Addr),
        .i_Psum_Rd_Data    (psum_rd_data),
        .o_Valid_WB_Out    (o_Valid_WB_Out),
        .o_Data_WB_Out     (o_Data_WB_Out),
        .o_Flag_Finish_Out (o_Flag_Finish_Out),
        .o_Illegal_Op      (o_Illegal_Op)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // PSUM SRAM model, 1-cycle read latency; garbage when not reading
    logic [19:0] mem [64];
    always @(posedge CLK)
        psum_rd_data <= o_Psum_Rd_En ? mem[o_Psum_Rd_Addr] : 20'($urandom);

    // Ex-done responder: done ex_delay cycles after the start cycle, random noise at t+1
    int ex_delay = 5;
    int ex_cd    = 0;
    bit noise_next = 0;
    always @(negedge CLK) begin
        if (o_Ex_Start) ex_cd = ex_delay;
        noise_next = !RST && o_Instr_Ready && i_Instr_In[31] && (i_Instr_In[30:28] == 3'd2);
    end
    initial forever begin
        @(posedge CLK);
        #1;
        if (noise_next) i_Ex_Done = 1'($urandom_range(0, 1));
        else if (ex_cd > 0) begin
            ex_cd--;
            i_Ex_Done = (ex_cd == 0);
        end else i_Ex_Done = 1'b0;
    end

    // Reference model: expectations scheduled by absolute cycle
    bit          e_we [RNG];
    logic [6:0]  e_wa [RNG];
    logic [7:0]  e_wd [RNG];
    bit          e_st [RNG];
    bit          e_rd [RNG];
    logic [5:0]  e_ra [RNG];
    bit          e_wb [RNG];
    logic [19:0] e_wbd[RNG];
    bit          e_fin[RNG];
    bit          ex_pending = 0;
    int          ex_t = 0;
    int          free_at = 0;
    bit          m_ill = 0;
    int          wr_cnt = 0;

    always @(negedge CLK) begin
        int s;
        logic [2:0]  op;
        logic [19:0] fld;
        logic        m_ready;
        s = cyc % RNG;
        m_ready = !ex_pending && (cyc >= free_at);
        if (o_Sram_We) wr_cnt++;
        if (chk_en) begin
            chk("sram_we", 32'(o_Sram_We), 32'(e_we[s]));
            if (e_we[s]) begin
                chk("sram_addr", 32'(o_Sram_Addr), 32'(e_wa[s]));
                chk("sram_data", 32'(o_Sram_Data), 32'(e_wd[s]));
            end
            chk("ex_start", 32'(o_Ex_Start), 32'(e_st[s]));
            chk("rd_en", 32'(o_Psum_Rd_En), 32'(e_rd[s]));
            if (e_rd[s]) chk("rd_addr", 32'(o_Psum_Rd_Addr), 32'(e_ra[s]));
            chk("wb_valid", 32'(o_Valid_WB_Out), 32'(e_wb[s]));
            if (e_wb[s]) chk("wb_data", 32'(o_Data_WB_Out), 32'(e_wbd[s]));
            chk("finish", 32'(o_Flag_Finish_Out), 32'(e_fin[s]));
            chk("ready", 32'(o_Instr_Ready), 32'(m_ready));
            chk("illegal", 32'(o_Illegal_Op), 32'(m_ill));
        end
        e_we[s] = 0; e_st[s] = 0; e_rd[s] = 0; e_wb[s] = 0; e_fin[s] = 0;
        if (RST) begin
            for (int i = 0; i < RNG; i++) begin
                e_we[i] = 0; e_st[i] = 0; e_rd[i] = 0; e_wb[i] = 0; e_fin[i] = 0;
            end
            ex_pending = 0;
            free_at    = cyc + 1;
            m_ill      = 0;
        end else begin
            if (ex_pending && cyc >= ex_t + 2 && i_Ex_Done) begin
                ex_pending = 0;
                free_at    = cyc + 1;
            end
            if (m_ready && i_Instr_In[31]) begin
                op  = i_Instr_In[30:28];
                fld = i_Instr_In[27:8];
                case (op)
                    3'd1: begin
                        e_we[(cyc + 1) % RNG] = 1;
                        e_wa[(cyc + 1) % RNG] = fld[6:0];
                        e_wd[(cyc + 1) % RNG] = i_Instr_In[7:0];
                    end
                    3'd2: begin
                        ex_pending = 1;
                        ex_t       = cyc;
                        e_st[(cyc + 1) % RNG] = 1;
                    end
                    3'd3: begin
                        for (int k = 0; k < N; k++) begin
                            e_rd [(cyc + 1 + k) % RNG] = 1;
                            e_ra [(cyc + 1 + k) % RNG] = 6'((int'(fld[19:14]) + k) % 64);
                            e_wb [(cyc + 3 + k) % RNG] = 1;
                            e_wbd[(cyc + 3 + k) % RNG] = mem[(int'(fld[19:14]) + k) % 64];
                        end
                        e_fin[(cyc + N + 3) % RNG] = 1;
                        free_at = cyc + N + 4;
                    end
                    3'd0: ;
                    default: begin
`ifdef DISPATCH_ILLEGAL_OP_EN
                        m_ill = 1;
`endif
                    end
                endcase
            end
        end
        cyc++;
    end

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [19:0] fld, input logic [7:0] d);
        return {1'b1, op, fld, d};
    endfunction

    task automatic send(input logic [31:0] w);
        bit done;
        done = 0;
        i_Instr_In = w;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge CLK);
            if (o_Instr_Ready) begin
                @(posedge CLK);
                #1;
                done = 1;
            end
        end
        i_Instr_In = '0;
        if (!done) chk("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int k = 0; k < 300 && !idle; k++) begin
            @(negedge CLK);
            idle = o_Instr_Ready;
        end
        @(posedge CLK);
        #1;
        if (!idle) chk("idle_timeout", 32'(idle), 32'd1);
    endtask

    initial begin
        int base_w;
        for (int a = 0; a < 64; a++) mem[a] = 20'(a * 3);
        RST = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", 32'(o_Instr_Ready), 32'd1);
        chk("rst_we", 32'(o_Sram_We), 32'd0);
        chk("rst_addr", 32'(o_Sram_Addr), 32'd0);
        chk("rst_data", 32'(o_Sram_Data), 32'd0);
        chk("rst_start", 32'(o_Ex_Start), 32'd0);
        chk("rst_rden", 32'(o_Psum_Rd_En), 32'd0);
        chk("rst_rdaddr", 32'(o_Psum_Rd_Addr), 32'd0);
        chk("rst_wbv", 32'(o_Valid_WB_Out), 32'd0);
        chk("rst_wbd", 32'(o_Data_WB_Out), 32'd0);
        chk("rst_fin", 32'(o_Flag_Finish_Out), 32'd0);
        chk("rst_ill", 32'(o_Illegal_Op), 32'd0);
        @(posedge CLK);
        #1;
        chk_en = 1;
        RST    = 1'b0;
        repeat (4) @(posedge CLK);
        #1;

        send(mk(3'd1, 20'd5, 8'h9F));
        send(mk(3'd1, 20'hFFF85, 8'h60));
        wait_idle();
        base_w = wr_cnt;
        for (int i = 0; i < 90; i++) send(mk(3'd1, 20'($urandom), 8'($urandom)));
        wait_idle();
        chk("b2b_writes", 32'(wr_cnt - base_w), 32'd90);

        ex_delay = 9;
        send(mk(3'd2, 20'd0, 8'd0));
        wait_idle();

        send(mk(3'd3, {6'd60, 14'h0}, 8'd0));
        wait_idle();

        ex_delay = 4;
        send(mk(3'd2, 20'h12345, 8'h11));
        send(mk(3'd3, {6'd10, 14'h3FFF}, 8'hAA));
        wait_idle();

        send(mk(3'd3, {6'd30, 14'h0}, 8'd0));
        repeat (6) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (N + 6) @(posedge CLK);
        #1;

        send(mk(3'd7, 20'hABCDE, 8'h55));
        repeat (3) @(posedge CLK);
        #1;
        send(mk(3'd4, 20'd1, 8'd1));
        wait_idle();

        for (int a = 0; a < 64; a++) mem[a] = 20'($urandom);
        for (int i = 0; i < 250; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10) begin
                i_Instr_In = {1'b0, 31'($urandom)};
                @(posedge CLK);
                #1;
                i_Instr_In = '0;
            end else if (r < 40) send(mk(3'd1, 20'($urandom), 8'($urandom)));
            else if (r < 58) begin
                ex_delay = $urandom_range(1, 12);
                send(mk(3'd2, 20'($urandom), 8'($urandom)));
            end else if (r < 75) send(mk(3'd3, 20'($urandom), 8'($urandom)));
            else if (r < 88) send(mk(3'd0, 20'($urandom), 8'($urandom)));
            else send(mk(3'($urandom_range(4, 7)), 20'($urandom), 8'($urandom)));
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end
        wait_idle();
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
